dclk_monitor: RTL and testbench

Measures the divided clock `dclk` produced by the one-hot divider stage and checks its shape. It sits directly downstream of the divider in the same `clk` domain. For every complete `dclk` period it reports the high and low lengths in `clk` cycles and counts periods. It also flags duty-cycle mismatches and counter saturation as sticky status bits for the bench and system logic.

---
 rtl/dclk_monitor_if.sv | 26 ++
 rtl/dclk_monitor.sv | 154 +++++++++++++++
 tb/tb_dclk_monitor.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dclk_monitor_if.sv
// Bus between the divided-clock monitor and its surroundings: measurement
// controls in, per-period lengths and sticky status out.
interface dclk_monitor_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PER_W = 16
) ();
  logic             en;
  logic             dclk;
  logic             clr_stats;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] lo_len;
  logic [PER_W-1:0] period_cnt;
  logic             valid;
  logic             err;
  logic             ovf;

  modport master (
    output en, dclk, clr_stats,
    input  hi_len, lo_len, period_cnt, valid, err, ovf
  );

  modport slave (
    input  en, dclk, clr_stats,
    output hi_len, lo_len, period_cnt, valid, err, ovf
  );
endinterface

// File: rtl/dclk_monitor.sv
// Measures high/low run lengths of a clk-synchronous divided clock and counts periods.
// Optional macro DCLK_MON_CHECK_EN compiles in the expected-length comparator driving err.
module dclk_monitor #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PER_W  = 16,
  parameter int unsigned EXP_HI = 4,
  parameter int unsigned EXP_LO = 2
) (
  input  logic           clk,
  input  logic           rst,
  dclk_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             dclk_q;
  logic [CNT_W-1:0] hi_run_q, hi_run_d;
  logic [CNT_W-1:0] lo_run_q, lo_run_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] hi_len_q, hi_len_d;
  logic [CNT_W-1:0] lo_len_q, lo_len_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic rise_c, fall_c, publish_c, sat_c, mism_c;

  assign rise_c = mon.dclk & ~dclk_q;
  assign fall_c = ~mon.dclk & dclk_q;

`ifdef DCLK_MON_CHECK_EN
  // Values about to be published, compared against the nominal shape
  assign mism_c = (hi_lat_q != CNT_W'(EXP_HI)) | (lo_run_q != CNT_W'(EXP_LO));
`else
  logic unused_exp;
  assign unused_exp = ^{32'(EXP_HI), 32'(EXP_LO)};
  assign mism_c     = 1'b0;
`endif

  // Next-state, run counters and published statistics
  always_comb begin
    state_d   = state_q;
    hi_run_d  = hi_run_q;
    lo_run_d  = lo_run_q;
    hi_lat_d  = hi_lat_q;
    hi_len_d  = hi_len_q;
    lo_len_d  = lo_len_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    ovf_d     = ovf_q;
    publish_c = 1'b0;
    sat_c     = 1'b0;

    if (!mon.en) begin
      state_d  = ST_IDLE;
      hi_run_d = '0;
      lo_run_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            state_d  = ST_HIGH;
            hi_run_d = RUN_ONE;
          end
        end
        ST_HIGH: begin
          if (fall_c) begin
            state_d  = ST_LOW;
            hi_lat_d = hi_run_q;
            lo_run_d = RUN_ONE;
          end else begin
            sat_c = (hi_run_q >= (RUN_MAX - RUN_ONE));
            if (hi_run_q != RUN_MAX) hi_run_d = hi_run_q + RUN_ONE;
          end
        end
        ST_LOW: begin
          if (rise_c) begin
            state_d   = ST_HIGH;
            publish_c = 1'b1;
            hi_run_d  = RUN_ONE;
          end else begin
            sat_c = (lo_run_q >= (RUN_MAX - RUN_ONE));
            if (lo_run_q != RUN_MAX) lo_run_d = lo_run_q + RUN_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    valid_d = publish_c;
    if (publish_c) begin
      hi_len_d = hi_lat_q;
      lo_len_d = lo_run_q;
    end

    // A clear still lets this cycle's event through
    if (mon.clr_stats) begin
      period_d = PER_W'(publish_c);
      err_d    = publish_c & mism_c;
      ovf_d    = sat_c;
    end else begin
      period_d = period_q + PER_W'(publish_c);
      err_d    = err_q | (publish_c & mism_c);
      ovf_d    = ovf_q | sat_c;
    end
  end

  // dclk_q resets high so a level already high at release is not a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dclk_q   <= 1'b1;
      hi_run_q <= '0;
      lo_run_q <= '0;
      hi_lat_q <= '0;
      hi_len_q <= '0;
      lo_len_q <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dclk_q   <= mon.dclk;
      hi_run_q <= hi_run_d;
      lo_run_q <= lo_run_d;
      hi_lat_q <= hi_lat_d;
      hi_len_q <= hi_len_d;
      lo_len_q <= lo_len_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign mon.hi_len     = hi_len_q;
  assign mon.lo_len     = lo_len_q;
  assign mon.period_cnt = period_q;
  assign mon.valid      = valid_q;
  assign mon.err        = err_q;
  assign mon.ovf        = ovf_q;

endmodule

// File: tb/tb_dclk_monitor.sv
// Self-checking bench for dclk_monitor: waveforms built from phase lists, expected
// publishes derived from the phase lengths themselves.
module tb_dclk_monitor;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PER_W  = 16;
  localparam int unsigned EXP_HI = 4;
  localparam int unsigned EXP_LO = 2;
  localparam int          SAT    = 255;

`ifdef DCLK_MON_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] lo;
    logic [PER_W-1:0] pc;
    logic             er;
    int               cyc;
  } pub_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dclk_monitor_if #(.CNT_W(CNT_W), .PER_W(PER_W)) mif ();

  dclk_monitor #(
    .CNT_W (CNT_W),
    .PER_W (PER_W),
    .EXP_HI(EXP_HI),
    .EXP_LO(EXP_LO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mif)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  pub_t got_q[$];
  pub_t exp_q[$];
  int   seg_hi[$];
  int   seg_lo[$];

  logic [PER_W-1:0] exp_pcnt = '0;
  logic             exp_err  = 1'b0;
  logic             exp_ovf  = 1'b0;

  int total = 0;
  int bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every published period as seen away from the active edge
  always @(negedge clk) begin
    pub_t r;
    if (!rst && mif.valid === 1'b1) begin
      r.hi  = mif.hi_len;
      r.lo  = mif.lo_len;
      r.pc  = mif.period_cnt;
      r.er  = mif.err;
      r.cyc = cyc;
      got_q.push_back(r);
    end
  end

  function automatic logic [CNT_W-1:0] sat_len(input int x);
    return (x > SAT) ? CNT_W'(SAT) : CNT_W'(x);
  endfunction

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      mif.dclk = v;
    end
  endtask

  // Every listed (hi,lo) period is closed by the next rise, so each one publishes
  task automatic run_periods();
    pub_t e;
    exp_q.delete();
    for (int i = 0; i < seg_hi.size(); i++) begin
      e.hi = sat_len(seg_hi[i]);
      e.lo = sat_len(seg_lo[i]);
      exp_pcnt = exp_pcnt + PER_W'(1);
      if (CHK && (int'(e.hi) != int'(EXP_HI) || int'(e.lo) != int'(EXP_LO))) exp_err = 1'b1;
      if (seg_hi[i] >= SAT || seg_lo[i] >= SAT) exp_ovf = 1'b1;
      e.pc  = exp_pcnt;
      e.er  = exp_err;
      e.cyc = seg_hi[i] + seg_lo[i];
      exp_q.push_back(e);
    end
    @(negedge clk);
    mif.en   = 1'b0;
    mif.dclk = 1'b0;
    @(negedge clk);
    got_q.delete();
    mif.en = 1'b1;
    for (int i = 0; i < seg_hi.size(); i++) begin
      drive(1'b1, seg_hi[i]);
      drive(1'b0, seg_lo[i]);
    end
    drive(1'b1, 2);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mif.en = 1'b0; mif.dclk = 1'b0; mif.clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    total += 6;
    if (mif.hi_len !== '0)     begin bad++; $display("FAIL rst_hi_len: got %0d want 0", mif.hi_len); end
    if (mif.lo_len !== '0)     begin bad++; $display("FAIL rst_lo_len: got %0d want 0", mif.lo_len); end
    if (mif.period_cnt !== '0) begin bad++; $display("FAIL rst_period: got %0d want 0", mif.period_cnt); end
    if (mif.valid !== 1'b0)    begin bad++; $display("FAIL rst_valid: got %0b want 0", mif.valid); end
    if (mif.err !== 1'b0)      begin bad++; $display("FAIL rst_err: got %0b want 0", mif.err); end
    if (mif.ovf !== 1'b0)      begin bad++; $display("FAIL rst_ovf: got %0b want 0", mif.ovf); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    seg_hi = '{4, 4, 4, 4};
    seg_lo = '{2, 2, 2, 2};
    run_periods();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL nom_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if ({got_q[i].hi, got_q[i].lo, got_q[i].pc, got_q[i].er} !== {exp_q[i].hi, exp_q[i].lo, exp_q[i].pc, exp_q[i].er}) begin
        bad++;
        $display("FAIL nom_pub%0d: got hi=%0d lo=%0d pc=%0d err=%0b want hi=%0d lo=%0d pc=%0d err=%0b", i,
                 got_q[i].hi, got_q[i].lo, got_q[i].pc, got_q[i].er, exp_q[i].hi, exp_q[i].lo, exp_q[i].pc, exp_q[i].er);
      end
      if (i > 0) begin
        total++;
        if (got_q[i].cyc - got_q[i-1].cyc != exp_q[i].cyc) begin
          bad++; $display("FAIL nom_gap%0d: got %0d want %0d", i, got_q[i].cyc - got_q[i-1].cyc, exp_q[i].cyc);
        end
      end
    end
    total += 2;
    if (mif.period_cnt !== 16'd4) begin bad++; $display("FAIL nom_period: got %0d want 4", mif.period_cnt); end
    if (mif.err !== 1'b0)         begin bad++; $display("FAIL nom_err: got %0b want 0", mif.err); end
  endtask

  task automatic test_err_sticky();
    seg_hi = '{4, 5, 4, 4};
    seg_lo = '{2, 2, 2, 2};
    run_periods();
    total++;
    if (got_q.size() != 4) begin bad++; $display("FAIL err_count: got %0d want 4", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if ({got_q[i].hi, got_q[i].lo, got_q[i].pc, got_q[i].er} !== {exp_q[i].hi, exp_q[i].lo, exp_q[i].pc, exp_q[i].er}) begin
        bad++;
        $display("FAIL err_pub%0d: got hi=%0d lo=%0d pc=%0d err=%0b want hi=%0d lo=%0d pc=%0d err=%0b", i,
                 got_q[i].hi, got_q[i].lo, got_q[i].pc, got_q[i].er, exp_q[i].hi, exp_q[i].lo, exp_q[i].pc, exp_q[i].er);
      end
    end
    total++;
    if (mif.err !== CHK) begin bad++; $display("FAIL err_sticky: got %0b want %0b", mif.err, CHK); end
    @(negedge clk); mif.clr_stats = 1'b1;
    @(negedge clk); mif.clr_stats = 1'b0;
    exp_pcnt = '0; exp_err = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    total += 2;
    if (mif.err !== 1'b0)      begin bad++; $display("FAIL clr_err: got %0b want 0", mif.err); end
    if (mif.period_cnt !== '0) begin bad++; $display("FAIL clr_period: got %0d want 0", mif.period_cnt); end
  endtask

  task automatic test_ovf();
    seg_hi = '{300};
    seg_lo = '{2};
    run_periods();
    total += 5;
    if (got_q.size() != 1)          begin bad++; $display("FAIL ovf_count: got %0d want 1", got_q.size()); end
    if (mif.ovf !== 1'b1)           begin bad++; $display("FAIL ovf_flag: got %0b want 1", mif.ovf); end
    if (mif.hi_len !== sat_len(300)) begin bad++; $display("FAIL ovf_hi_len: got %0d want %0d", mif.hi_len, sat_len(300)); end
    if (mif.lo_len !== 8'd2)        begin bad++; $display("FAIL ovf_lo_len: got %0d want 2", mif.lo_len); end
    if (mif.err !== exp_err)        begin bad++; $display("FAIL ovf_err: got %0b want %0b", mif.err, exp_err); end
  endtask

  task automatic test_en_abort();
    @(negedge clk); mif.en = 1'b0; mif.dclk = 1'b0;
    @(negedge clk); mif.en = 1'b1;
    got_q.delete();
    drive(1'b1, 3);
    drive(1'b0, 2);
    @(negedge clk); mif.en = 1'b0;
    @(negedge clk);
    @(negedge clk); mif.en = 1'b1;
    @(negedge clk);
    drive(1'b1, 3);
    drive(1'b0, 4);
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL abort_novalid: got %0d publishes want 0", got_q.size()); end
    drive(1'b1, 2);
    @(negedge clk);
    exp_pcnt = exp_pcnt + PER_W'(1);
    exp_err  = exp_err | CHK;
    total += 5;
    if (got_q.size() != 1)           begin bad++; $display("FAIL abort_count: got %0d want 1", got_q.size()); end
    if (mif.hi_len !== 8'd3)         begin bad++; $display("FAIL abort_hi: got %0d want 3", mif.hi_len); end
    if (mif.lo_len !== 8'd4)         begin bad++; $display("FAIL abort_lo: got %0d want 4", mif.lo_len); end
    if (mif.period_cnt !== exp_pcnt) begin bad++; $display("FAIL abort_period: got %0d want %0d", mif.period_cnt, exp_pcnt); end
    if (mif.ovf !== exp_ovf)         begin bad++; $display("FAIL abort_ovf: got %0b want %0b", mif.ovf, exp_ovf); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); mif.en = 1'b0; mif.dclk = 1'b0;
    @(negedge clk); mif.en = 1'b1;
    drive(1'b1, 3);
    #2 rst = 1'b1;
    #1;
    total += 5;
    if (mif.hi_len !== '0)     begin bad++; $display("FAIL amid_hi_len: got %0d want 0", mif.hi_len); end
    if (mif.lo_len !== '0)     begin bad++; $display("FAIL amid_lo_len: got %0d want 0", mif.lo_len); end
    if (mif.period_cnt !== '0) begin bad++; $display("FAIL amid_period: got %0d want 0", mif.period_cnt); end
    if (mif.err !== 1'b0)      begin bad++; $display("FAIL amid_err: got %0b want 0", mif.err); end
    if (mif.ovf !== 1'b0)      begin bad++; $display("FAIL amid_ovf: got %0b want 0", mif.ovf); end
    @(negedge clk); rst = 1'b0;
    got_q.delete();
    drive(1'b1, 2);
    drive(1'b0, 2);
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 2);
    @(negedge clk);
    exp_pcnt = PER_W'(1); exp_err = CHK; exp_ovf = 1'b0;
    total += 4;
    if (got_q.size() != 1)       begin bad++; $display("FAIL amid_count: got %0d want 1", got_q.size()); end
    if (mif.hi_len !== 8'd3)     begin bad++; $display("FAIL amid_hi: got %0d want 3", mif.hi_len); end
    if (mif.period_cnt !== 16'd1) begin bad++; $display("FAIL amid_pc: got %0d want 1", mif.period_cnt); end
    if (mif.err !== exp_err)     begin bad++; $display("FAIL amid_err2: got %0b want %0b", mif.err, exp_err); end
  endtask

  task automatic test_clr_on_publish();
    @(negedge clk); mif.en = 1'b0; mif.dclk = 1'b0; mif.clr_stats = 1'b1;
    @(negedge clk); mif.clr_stats = 1'b0; mif.en = 1'b1;
    drive(1'b1, 4);
    drive(1'b0, 2);
    repeat (6) begin
      drive(1'b1, 4);
      drive(1'b0, 2);
    end
    total++;
    if (mif.period_cnt !== 16'd6) begin bad++; $display("FAIL cp_pre: got %0d want 6", mif.period_cnt); end
    @(negedge clk); mif.dclk = 1'b1; mif.clr_stats = 1'b1;
    @(negedge clk); mif.clr_stats = 1'b0;
    total += 5;
    if (mif.valid !== 1'b1)       begin bad++; $display("FAIL cp_valid: got %0b want 1", mif.valid); end
    if (mif.period_cnt !== 16'd1) begin bad++; $display("FAIL cp_period: got %0d want 1", mif.period_cnt); end
    if (mif.hi_len !== 8'd4)      begin bad++; $display("FAIL cp_hi: got %0d want 4", mif.hi_len); end
    if (mif.lo_len !== 8'd2)      begin bad++; $display("FAIL cp_lo: got %0d want 2", mif.lo_len); end
    if (mif.err !== 1'b0)         begin bad++; $display("FAIL cp_err: got %0b want 0", mif.err); end
    exp_pcnt = PER_W'(1); exp_err = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(3, 6));
      seg_hi.delete(); seg_lo.delete();
      for (int k = 0; k < n; k++) begin
        seg_hi.push_back(int'($urandom_range(1, 8)));
        seg_lo.push_back(int'($urandom_range(1, 8)));
      end
      run_periods();
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rnd%0d_count: got %0d want %0d", r, got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        total++;
        if ({got_q[i].hi, got_q[i].lo, got_q[i].pc, got_q[i].er} !== {exp_q[i].hi, exp_q[i].lo, exp_q[i].pc, exp_q[i].er}) begin
          bad++;
          $display("FAIL rnd%0d_pub%0d: got hi=%0d lo=%0d pc=%0d err=%0b want hi=%0d lo=%0d pc=%0d err=%0b", r, i,
                   got_q[i].hi, got_q[i].lo, got_q[i].pc, got_q[i].er, exp_q[i].hi, exp_q[i].lo, exp_q[i].pc, exp_q[i].er);
        end
        if (i > 0) begin
          total++;
          if (got_q[i].cyc - got_q[i-1].cyc != exp_q[i].cyc) begin
            bad++; $display("FAIL rnd%0d_gap%0d: got %0d want %0d", r, i, got_q[i].cyc - got_q[i-1].cyc, exp_q[i].cyc);
          end
        end
      end
      total += 3;
      if (mif.period_cnt !== exp_pcnt) begin bad++; $display("FAIL rnd%0d_period: got %0d want %0d", r, mif.period_cnt, exp_pcnt); end
      if (mif.err !== exp_err)         begin bad++; $display("FAIL rnd%0d_err: got %0b want %0b", r, mif.err, exp_err); end
      if (mif.ovf !== exp_ovf)         begin bad++; $display("FAIL rnd%0d_ovf: got %0b want %0b", r, mif.ovf, exp_ovf); end
    end
  endtask

  initial begin
    mif.en = 1'b0;
    mif.dclk = 1'b0;
    mif.clr_stats = 1'b0;
    test_reset();
    test_nominal();
    test_err_sticky();
    test_ovf();
    test_en_abort();
    test_reset_mid();
    test_clr_on_publish();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
